// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: prefix stall mask, one-cycle flush with
// redirect PC, saturating stall-cycle counter and sticky runaway-stall watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES     = 6,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [STAGES-1:0] STALL_REQ,
  input  logic              FLUSH_REQ,
  input  logic [PC_W-1:0]   FLUSH_PC,
  input  logic              CLR_CNT,
  output logic [STAGES-1:0] STALL,
  output logic              FLUSH,
  output logic [PC_W-1:0]   NEW_PC,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic              WDOG_TRIP
);

  localparam int unsigned RUN_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(WDOG_LIMIT);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(WDOG_LIMIT - 1);

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [STAGES-1:0] w_mask;
  logic [STAGES-1:0] w_stall;
  logic              w_acc;
  logic              w_stall_any;
  logic              w_accept;
  logic [PC_W-1:0]   r_new_pc;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [RUN_W-1:0]  r_run;
  logic              r_trip;

  // Scan from the deepest stage down so every stage below a requester holds too.
  always_comb begin
    w_mask = '0;
    w_acc  = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_acc = w_acc | STALL_REQ[STAGES-1-i];
      w_mask[STAGES-1-i] = w_acc;
    end
  end

  always_comb begin
    w_stall  = '0;
    w_accept = 1'b0;
    w_next   = r_state;
    case (r_state)
      S_IDLE: begin
        w_stall  = RST ? '0 : w_mask;
        w_accept = FLUSH_REQ;
        if (FLUSH_REQ) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_stall_any = |w_stall;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_new_pc <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_new_pc <= FLUSH_PC;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (CLR_CNT) begin
      r_stall_cnt <= '0;
    end else if (w_stall_any && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Trip on the edge that completes WDOG_LIMIT consecutive stalled cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_run  <= '0;
      r_trip <= 1'b0;
    end else if (!w_stall_any) begin
      r_run <= '0;
    end else begin
      if (r_run != RUN_MAX) r_run <= r_run + 1'b1;
      if (r_run >= RUN_TRIP) r_trip <= 1'b1;
    end
  end

  assign STALL     = w_stall;
  assign FLUSH     = (r_state == S_FLUSH);
  assign NEW_PC    = r_new_pc;
  assign STALL_CNT = r_stall_cnt;
  assign WDOG_TRIP = r_trip;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver pushes model-predicted outputs,
// the monitor pops and compares them every negative clock edge.
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 6;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 4;
  localparam int LIMIT  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [STAGES-1:0] STALL_REQ = 6'h3F;
  logic              FLUSH_REQ = 1'b1;
  logic [PC_W-1:0]   FLUSH_PC = 32'h0;
  logic              CLR_CNT = 1'b0;
  logic [STAGES-1:0] STALL;
  logic              FLUSH;
  logic [PC_W-1:0]   NEW_PC;
  logic [CNT_W-1:0]  STALL_CNT;
  logic              WDOG_TRIP;

  pipe_hazard_ctrl #(
    .STAGES(STAGES), .PC_W(PC_W), .CNT_W(CNT_W), .WDOG_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST), .STALL_REQ(STALL_REQ), .FLUSH_REQ(FLUSH_REQ),
    .FLUSH_PC(FLUSH_PC), .CLR_CNT(CLR_CNT), .STALL(STALL), .FLUSH(FLUSH),
    .NEW_PC(NEW_PC), .STALL_CNT(STALL_CNT), .WDOG_TRIP(WDOG_TRIP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [STAGES-1:0] stall;
    logic              flush;
    logic [PC_W-1:0]   npc;
    logic [CNT_W-1:0]  cnt;
    logic              trip;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  bit          m_flush;
  logic [31:0] m_npc;
  int          m_cnt;
  int          m_run;
  bit          m_trip;

  function automatic logic [STAGES-1:0] ref_mask(logic [STAGES-1:0] r);
    int h = -1;
    for (int i = 0; i < STAGES; i++) if (r[i]) h = i;
    if (h < 0) return '0;
    return STAGES'((1 << (h + 1)) - 1);
  endfunction

  function automatic logic [STAGES-1:0] ref_stall();
    if (RST || m_flush) return '0;
    return ref_mask(STALL_REQ);
  endfunction

  task automatic model_reset();
    m_flush = 0; m_npc = '0; m_cnt = 0; m_run = 0; m_trip = 0;
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_edge();
    bit nz;
    if (RST) begin
      model_reset();
    end else begin
      nz = (ref_stall() != 0);
      if (CLR_CNT) m_cnt = 0;
      else if (nz && m_cnt < CNT_MAX) m_cnt++;
      if (nz) begin
        if (m_run < LIMIT) m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run >= LIMIT) m_trip = 1;
      if (m_flush) m_flush = 0;
      else if (FLUSH_REQ) begin
        m_flush = 1;
        m_npc   = FLUSH_PC;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [STAGES-1:0] req,
                      input logic fr, input logic [31:0] pc, input logic clr);
    exp_t e;
    @(posedge CLK);
    model_edge();
    #1;
    RST = rst; STALL_REQ = req; FLUSH_REQ = fr; FLUSH_PC = pc; CLR_CNT = clr;
    if (rst) model_reset();
    e.stall = ref_stall();
    e.flush = m_flush && !rst;
    e.npc   = m_npc;
    e.cnt   = CNT_W'(m_cnt);
    e.trip  = m_trip;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("STALL",     32'(STALL),     32'(e.stall));
        chk("FLUSH",     32'(FLUSH),     32'(e.flush));
        chk("NEW_PC",    NEW_PC,         e.npc);
        chk("STALL_CNT", 32'(STALL_CNT), 32'(e.cnt));
        chk("WDOG_TRIP", 32'(WDOG_TRIP), 32'(e.trip));
      end
    end
  end

  initial begin : driver
    logic [STAGES-1:0] r;
    model_reset();
    // reset with everything requested, then release
    step(1, 6'h3F, 1, 32'h1234_5678, 0);
    step(1, 6'h3F, 1, 32'h1234_5678, 0);
    step(0, 6'h3F, 1, 32'hA000_0000, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    // single-bit walk and a two-requester mask
    for (int k = 0; k < STAGES; k++) begin
      r = '0; r[k] = 1'b1;
      step(0, r, 0, 32'h0, 0);
    end
    step(0, 6'b000101, 0, 32'h0, 0);
    // stall plus flush in the same cycle
    step(0, 6'b001000, 1, 32'hBFC0_0380, 0);
    step(0, 6'b001000, 0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0);
    // flush request held for three cycles
    for (int i = 0; i < 3; i++) step(0, 6'h00, 1, 32'h8000_0100 + 32'(i * 4), 0);
    step(0, 6'h00, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    // reset landing in the flush cycle, no replay afterwards
    step(0, 6'h00, 1, 32'hDEAD_BEEF, 0);
    step(1, 6'h00, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    // counter: five stalls, then clear on a stalled edge
    for (int i = 0; i < 5; i++) step(0, 6'b000010, 0, 32'h0, 0);
    step(0, 6'b000010, 0, 32'h0, 1);
    step(0, 6'b000000, 0, 32'h0, 0);
    step(0, 6'b000000, 0, 32'h0, 0);
    // watchdog: 7 on, 1 off, 7 on, 1 off, then 8 on
    step(1, 6'h00, 0, 32'h0, 0);
    for (int i = 0; i < 7; i++) step(0, 6'b000100, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    for (int i = 0; i < 7; i++) step(0, 6'b100000, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 6'b000001, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 6'h00, 0, 32'h0, 0);
    // counter saturation over a long stall run
    for (int i = 0; i < 20; i++) step(0, 6'b010000, 0, 32'h0, 0);
    step(0, 6'h00, 0, 32'h0, 0);
    step(1, 6'h00, 0, 32'h0, 0);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0, 1: r = '0;
        2:    r = STAGES'($urandom);
        default: begin r = '0; r[$urandom_range(0, STAGES - 1)] = 1'b1; end
      endcase
      if ($urandom_range(0, 9) < 6 && i % 60 > 40) r = 6'b001000;
      step(($urandom_range(0, 59) == 0), r, ($urandom_range(0, 4) == 0),
           $urandom, ($urandom_range(0, 11) == 0));
    end
    step(0, 6'h00, 0, 32'h0, 0);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
